// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, bit positions, FSM states.
// Latency: n/a (constants and one pure combinational helper).
// Backpressure: n/a.
package led_seq_pkg;

  // Slave word offsets
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_LENGTH  = 3'd3;
  localparam logic [2:0] ADDR_PATTERN = 3'd4;

  // CTRL bits
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Number of steps actually played: 0 behaves as 1, anything above the
  // pattern capacity is clipped to it. The register itself is not modified.
  function automatic logic [3:0] eff_len(input logic [3:0] length, input logic [3:0] steps);
    if (length == 4'd0)
      return 4'd1;
    else if (length > steps)
      return steps;
    else
      return length;
  endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Step-interval down-counter: load value, count down while enabled, flag when zero.
// Latency: load/decrement visible one cycle after the enabling edge; zero flag is combinational on the count.
// Backpressure: none; counter saturates at zero.
module led_seq_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                zero
);

  logic [PERIOD_W-1:0] cnt;

  // Load has priority so a fresh interval always starts from the full value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: Avalon-MM slave register file plus a write master that steps the PIO data register.
// Latency: first master write one cycle after RUN is registered; strobes PERIOD+2 cycles apart.
// Backpressure: none; the PIO accepts every write in one cycle, slave reads are zero-wait combinational.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int STEPS    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  localparam int PW = STEPS * LED_W;

  // Register file
  logic                ctrl_run;
  logic                ctrl_loop;
  logic                ctrl_irq_en;
  logic                done;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          length;
  logic [PW-1:0]       pattern;

  // Sequencer state
  state_t     state;
  logic [3:0] idx;
  logic       tmr_zero;

  // Slave write decode
  logic wr_en, ctrl_wr, status_wr, period_wr, length_wr, pattern_wr;
  assign wr_en      = chipselect & ~write_n;
  assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
  assign status_wr  = wr_en && (address == ADDR_STATUS);
  assign period_wr  = wr_en && (address == ADDR_PERIOD);
  assign length_wr  = wr_en && (address == ADDR_LENGTH);
  assign pattern_wr = wr_en && (address == ADDR_PATTERN);

  logic busy;
  assign busy = (state != ST_IDLE);

  // A CTRL write clearing RUN stops the sequencer on the same edge it lands,
  // so no strobe can slip out after it.
  logic run_clr, abort, start;
  assign run_clr = ctrl_wr && !writedata[CTRL_RUN];
  assign abort   = run_clr && busy;
  assign start   = ctrl_run && !run_clr;

  logic [3:0] len_eff;
  logic       last_step;
  assign len_eff   = eff_len(length, 4'(STEPS));
  // >= rather than == so a LENGTH shortened mid-run still ends the pass
  assign last_step = (({1'b0, idx} + 5'd1) >= {1'b0, len_eff});

  // Non-looping pass finished this cycle: set DONE, drop RUN, return to IDLE
  logic seq_end;
  assign seq_end = (state == ST_WAIT) && tmr_zero && last_step && !ctrl_loop && !abort;

  // Pattern step i, zero-extended to the bus width
  function automatic logic [31:0] step_word(input logic [3:0] i);
    logic [PW-1:0] sh;
    logic [31:0]   w;
    sh = pattern >> (i * LED_W);
    w  = '0;
    w[LED_W-1:0] = sh[LED_W-1:0];
    return w;
  endfunction

  // Software-visible registers; completion overrides a simultaneous CTRL write and DONE clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_run    <= 1'b0;
      ctrl_loop   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      period      <= '0;
      length      <= '0;
      pattern     <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_run    <= writedata[CTRL_RUN];
        ctrl_loop   <= writedata[CTRL_LOOP];
        ctrl_irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (seq_end)
        ctrl_run <= 1'b0;
      if (seq_end)
        done <= 1'b1;
      else if (status_wr && writedata[STATUS_DONE])
        done <= 1'b0;
      if (period_wr)
        period <= writedata[PERIOD_W-1:0];
      if (length_wr)
        length <= writedata[3:0];
      if (pattern_wr)
        pattern <= writedata[PW-1:0];
    end
  end

  // Sequencer FSM; master strobe is registered on the edge that enters WRITE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_WRITE;
            idx          <= '0;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= step_word(4'd0);
          end
        end
        ST_WRITE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            if (!last_step) begin
              state        <= ST_WRITE;
              idx          <= idx + 4'd1;
              m_chipselect <= 1'b1;
              m_write_n    <= 1'b0;
              m_writedata  <= step_word(idx + 4'd1);
            end else if (ctrl_loop) begin
              state        <= ST_WRITE;
              idx          <= '0;
              m_chipselect <= 1'b1;
              m_write_n    <= 1'b0;
              m_writedata  <= step_word(4'd0);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (abort) begin
        state        <= ST_IDLE;
        m_chipselect <= 1'b0;
        m_write_n    <= 1'b1;
      end
    end
  end

  // Interval counter reloads PERIOD only in WRITE, so a PERIOD change never hits mid-interval
  led_seq_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state == ST_WRITE),
    .en       (state == ST_WAIT),
    .load_val (period),
    .zero     (tmr_zero)
  );

  // Zero-wait combinational read mux; unmapped offsets read 0
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_CTRL: begin
          readdata[CTRL_RUN]    = ctrl_run;
          readdata[CTRL_LOOP]   = ctrl_loop;
          readdata[CTRL_IRQ_EN] = ctrl_irq_en;
        end
        ADDR_STATUS: begin
          readdata[STATUS_BUSY] = busy;
          readdata[STATUS_DONE] = done;
        end
        ADDR_PERIOD:  readdata[PERIOD_W-1:0] = period;
        ADDR_LENGTH:  readdata[3:0]          = length;
        ADDR_PATTERN: readdata[PW-1:0]       = pattern;
        default:      readdata               = '0;
      endcase
    end
  end

  assign irq       = done & ctrl_irq_en;
  assign m_address = 2'b00;

  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: randomized and directed sequences, scoreboard on master writes.
// Latency: expected strobe cycles derived from start edge, step count and PERIOD.
// Backpressure: none; monitor flags any unexpected or mistimed master write.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  localparam int LED_W    = 4;
  localparam int STEPS    = 8;
  localparam int PERIOD_W = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  led_seq_ctrl #(.LED_W(LED_W), .STEPS(STEPS), .PERIOD_W(PERIOD_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq          (irq),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k (and before the next), cyc == k
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every master strobe must match the next expected write in data and cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && m_chipselect) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%08h at cycle %0d, expected no write", m_writedata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", m_writedata, e.d);
        check("wr_cycle", 32'(cyc), 32'(e.t));
        check("wr_strobe", {29'd0, m_write_n, m_address}, 32'd0);
      end
    end
  end

  // All bus tasks are entered and left 1 time unit after a rising edge
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, output int edge_cyc);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    edge_cyc   = cyc;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d, output logic ir);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    d  = readdata;
    ir = irq;
    @(posedge clk); #1;
    chipselect = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Reference: step k of a pass is nibble k of PATTERN, issued (PERIOD+2)*k cycles
  // after the first strobe; DONE lands (PERIOD+2) cycles after the final strobe.
  task automatic run_once(input logic [31:0] pat, input int len, input int per, input bit ie);
    int          n, t0, eff, done_t;
    logic [31:0] d;
    logic        ir;
    exp_t        e;
    bus_wr(ADDR_PATTERN, pat, n);
    bus_wr(ADDR_LENGTH, 32'(len), n);
    bus_wr(ADDR_PERIOD, 32'(per), n);
    bus_wr(ADDR_CTRL, {29'd0, ie, 1'b0, 1'b1}, n);
    t0  = n + 1;
    eff = (len == 0) ? 1 : ((len > STEPS) ? STEPS : len);
    for (int k = 0; k < eff; k++) begin
      e.t = t0 + k * (per + 2);
      e.d = (pat >> (4 * k)) & 32'hF;
      exp_q.push_back(e);
    end
    done_t = t0 + eff * (per + 2);
    wait_cyc(done_t - 1);
    bus_rd(ADDR_STATUS, d, ir);
    check("busy_before_done", d, 32'h1);
    check("irq_before_done", {31'd0, ir}, 32'd0);
    bus_rd(ADDR_STATUS, d, ir);
    check("done_set", d, 32'h2);
    check("irq_at_done", {31'd0, ir}, {31'd0, ie});
    bus_rd(ADDR_CTRL, d, ir);
    check("run_cleared", d, {29'd0, ie, 2'b00});
    drain();
    bus_wr(ADDR_STATUS, 32'h2, n);
    bus_rd(ADDR_STATUS, d, ir);
    check("done_cleared", d, 32'h0);
    check("irq_cleared", {31'd0, ir}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          n, t0;
    logic [31:0] d;
    logic        ir;
    exp_t        e;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check("rst_m_wn", {31'd0, m_write_n}, 32'd1);
    check("rst_m_wd", m_writedata, 32'd0);
    check("rst_m_addr", {30'd0, m_address}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 6; a++) begin
      bus_rd(3'(a), d, ir);
      check("rst_read", d, 32'd0);
    end

    // Readback
    bus_wr(ADDR_PATTERN, 32'h8421_8421, n);
    bus_rd(ADDR_PATTERN, d, ir);
    check("pattern_readback", d, 32'h8421_8421);

    // Single pass
    run_once(32'h0000_4321, 4, 3, 1'b1);

    // Length clamping
    run_once(32'h8765_4321, 0, 1, 1'b0);
    run_once(32'hFEDC_BA98, 15, 0, 1'b1);

    // Randomized passes
    for (int i = 0; i < 6; i++)
      run_once($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));

    // Loop then abort
    bus_wr(ADDR_LENGTH, 32'd2, n);
    bus_wr(ADDR_PATTERN, 32'hA5, n);
    bus_wr(ADDR_PERIOD, 32'd0, n);
    bus_wr(ADDR_CTRL, 32'h3, n);
    t0 = n + 1;
    for (int k = 0; k < 10; k++) begin
      e.t = t0 + 2 * k;
      e.d = (k % 2 == 0) ? 32'h5 : 32'hA;
      exp_q.push_back(e);
    end
    wait_cyc(t0 + 5);
    bus_rd(ADDR_STATUS, d, ir);
    check("loop_busy", d, 32'h1);
    wait_cyc(t0 + 12);
    bus_rd(ADDR_STATUS, d, ir);
    check("loop_busy_late", d, 32'h1);
    wait_cyc(t0 + 18);
    bus_wr(ADDR_CTRL, 32'h0, n);
    bus_rd(ADDR_STATUS, d, ir);
    check("abort_idle", d, 32'h0);
    check("abort_irq", {31'd0, ir}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    drain();

    // Reset mid-WAIT
    bus_wr(ADDR_PATTERN, 32'h0000_4321, n);
    bus_wr(ADDR_LENGTH, 32'd4, n);
    bus_wr(ADDR_PERIOD, 32'd20, n);
    bus_wr(ADDR_CTRL, 32'h5, n);
    t0  = n + 1;
    e.t = t0;
    e.d = 32'h1;
    exp_q.push_back(e);
    wait_cyc(t0 + 5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check("mid_rst_m_wn", {31'd0, m_write_n}, 32'd1);
    check("mid_rst_m_wd", m_writedata, 32'd0);
    check("mid_rst_m_addr", {30'd0, m_address}, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    chipselect = 1'b1; write_n = 1'b1; address = ADDR_STATUS;
    #1;
    check("mid_rst_status", readdata, 32'd0);
    address = ADDR_CTRL;
    #1;
    check("mid_rst_ctrl", readdata, 32'd0);
    chipselect = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
